// File: rtl/ram_wr_arbiter.sv
// Round-robin write-port arbiter for RAM port C (CPU = req0, loader = req1).
// Define RAM_CLEAR_EN to run a FILL clear pass over every word after reset.
module ram_wr_arbiter #(
   parameter int               AWIDTH = 8,
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] FILL   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [WIDTH-1:0]  data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [WIDTH-1:0]  data1,
   output logic              ack1,
   output logic              busy,
   output logic [AWIDTH-1:0] port_c_address,
   output logic [WIDTH-1:0]  port_c_data,
   output logic              port_c_we
);

   typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

`ifdef RAM_CLEAR_EN
   localparam state_t RESET_STATE = S_CLEAR;
   localparam logic   RESET_BUSY  = 1'b1;
`else
   localparam state_t RESET_STATE = S_IDLE;
   localparam logic   RESET_BUSY  = 1'b0;
`endif

   localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              we_q, we_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              last_q, last_d;   // 1: requester 1 won the most recent grant
   logic              elig0_s, elig1_s, grant0_s, grant1_s;

   // Next-state: clear sweep, or round-robin grant among eligible requesters
   always_comb begin
      elig0_s  = req0 & ~ack0_q;
      elig1_s  = req1 & ~ack1_q;
      grant0_s = elig0_s & (~elig1_s | last_q);
      grant1_s = elig1_s & ~grant0_s;

      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      busy_d  = busy_q;
      last_d  = last_q;

      case (state_q)
         S_CLEAR: begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = FILL;
            busy_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            // The final word leaves CLEAR; busy drops with the next (idle) cycle
            if (cnt_q == LAST_ADDR) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_IDLE: begin
            busy_d = 1'b0;
            if (grant0_s) begin
               we_d   = 1'b1;
               addr_d = addr0;
               data_d = data0;
               ack0_d = 1'b1;
               last_d = 1'b0;
            end else if (grant1_s) begin
               we_d   = 1'b1;
               addr_d = addr1;
               data_d = data1;
               ack1_d = 1'b1;
               last_d = 1'b1;
            end else begin
               we_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= RESET_BUSY;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
      end
   end

   assign port_c_address = addr_q;
   assign port_c_data    = data_q;
   assign port_c_we      = we_q;
   assign ack0           = ack0_q;
   assign ack1           = ack1_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Self-checking bench for ram_wr_arbiter: directed cases plus randomized
// requesters, checked every cycle against a behavioural model.
module tb_ram_wr_arbiter;
   localparam int         AW     = 8;
   localparam int         DW     = 8;
   localparam logic [7:0] FILL_V = 8'h5A;
`ifdef RAM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, ack0, ack1, busy, port_c_we;
   logic [AW-1:0] addr0, addr1, port_c_address;
   logic [DW-1:0] data0, data1, port_c_data;
   logic [DW-1:0] dut_mem [256];

   int total = 0;
   int bad   = 0;

   ram_wr_arbiter #(.AWIDTH(AW), .WIDTH(DW), .FILL(FILL_V)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
      .busy(busy), .port_c_address(port_c_address),
      .port_c_data(port_c_data), .port_c_we(port_c_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts remaining clear words, otherwise picks a winner
   initial begin : model
      bit         m_we, m_ack0, m_ack1, m_busy, last1, g0, g1;
      logic [7:0] m_addr, m_data;
      int         clr_left, clr_addr;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_we = 0; m_ack0 = 0; m_ack1 = 0; m_addr = 8'h00; m_data = 8'h00;
            m_busy = CLR; clr_left = CLR ? 256 : 0; clr_addr = 0; last1 = 1;
         end else if (clr_left > 0) begin
            m_we = 1; m_ack0 = 0; m_ack1 = 0; m_busy = 1;
            m_addr = clr_addr[7:0]; m_data = FILL_V;
            clr_addr++; clr_left--;
         end else begin
            m_busy = 0;
            g0 = req0 && !m_ack0;
            g1 = req1 && !m_ack1;
            if (g0 && g1) begin
               if (last1) g1 = 0; else g0 = 0;
            end
            m_ack0 = g0; m_ack1 = g1; m_we = g0 || g1;
            if (g0) begin m_addr = addr0; m_data = data0; last1 = 0; end
            if (g1) begin m_addr = addr1; m_data = data1; last1 = 1; end
         end
         #1;
         chk("we", port_c_we, m_we);
         chk("ack0", ack0, m_ack0);
         chk("ack1", ack1, m_ack1);
         chk("busy", busy, m_busy);
         chk("addr", port_c_address, m_addr);
         chk("data", port_c_data, m_data);
         chk("ack_excl", ack0 & ack1, 0);
         if (port_c_we === 1'b1) dut_mem[port_c_address] = port_c_data;
      end
   end

   // Legal requester behaviour: hold until ack, then new write or release
   task automatic step_req(input logic ack, inout logic req, inout logic [7:0] a, inout logic [7:0] d);
      if (req) begin
         if (ack) begin
            if ($urandom_range(0, 1) == 0) begin
               a = 8'($urandom); d = 8'($urandom);
            end else begin
               req = 1'b0;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         req = 1'b1; a = 8'($urandom); d = 8'($urandom);
      end
   endtask

`ifdef RAM_CLEAR_EN
   task automatic run_clear(input string name);
      int ok = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #2;
         if (port_c_we === 1'b1 && port_c_address === i[7:0] &&
             port_c_data === FILL_V && busy === 1'b1) ok++;
      end
      chk(name, ok, 256);
      @(posedge clk); #2;
      chk("clear_busy_fall", busy, 0);
      chk("clear_we_fall", port_c_we, 0);
   endtask

   task automatic wait_addr(input logic [7:0] a);
      int n   = 0;
      bit hit = 0;
      while (!hit && n < 600) begin
         @(posedge clk); #2;
         n++;
         if (port_c_we === 1'b1 && port_c_address === a) hit = 1;
      end
      chk("wait_addr", hit, 1);
   endtask
`endif

   initial begin : stim
      int cnt;
      rst = 1; req0 = 0; req1 = 0;
      addr0 = 8'h00; data0 = 8'h00; addr1 = 8'h00; data1 = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_we", port_c_we, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_busy", busy, CLR);
      @(negedge clk); rst = 0;

`ifdef RAM_CLEAR_EN
      run_clear("clear_seq");
      chk("mem00", dut_mem[8'h00], FILL_V);
      chk("mem7f", dut_mem[8'h7F], FILL_V);
      chk("memff", dut_mem[8'hFF], FILL_V);

      // Request raised mid-clear waits until the sweep completes
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      wait_addr(8'h40);
      @(negedge clk); req0 = 1; addr0 = 8'h55; data0 = 8'h77;
      cnt = 0;
      begin : wait_idle
         bit early = 0;
         while (busy === 1'b1 && cnt < 400) begin
            @(posedge clk); #2;
            cnt++;
            if (busy === 1'b1 && ack0 === 1'b1) early = 1;
         end
         chk("no_ack_in_clear", early, 0);
      end
      chk("clear_done_busy", busy, 0);
      chk("first_grant_we", port_c_we, 1);
      chk("first_grant_ack0", ack0, 1);
      chk("first_grant_addr", port_c_address, 8'h55);
      chk("first_grant_data", port_c_data, 8'h77);
      @(negedge clk); req0 = 0;

      // Reset mid-clear restarts the sweep at address 0
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      wait_addr(8'h80);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      run_clear("clear_restart");
`endif

      // Tie straight after reset: requester 0 first, then strict alternation
      @(negedge clk);
      req0 = 1; addr0 = 8'h20; data0 = 8'h11;
      req1 = 1; addr1 = 8'h30; data1 = 8'h22;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #2;
         chk("tie_ack0", ack0, (k % 2 == 0) ? 1 : 0);
         chk("tie_ack1", ack1, (k % 2 == 0) ? 0 : 1);
         chk("tie_addr", port_c_address, (k % 2 == 0) ? 8'h20 : 8'h30);
         chk("tie_data", port_c_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      end
      @(negedge clk); req0 = 0; req1 = 0;
      @(posedge clk); #2;
      chk("idle_we", port_c_we, 0);

      // Single CPU write
      @(negedge clk); req0 = 1; addr0 = 8'h10; data0 = 8'hAA;
      @(posedge clk); #2;
      chk("single_we", port_c_we, 1);
      chk("single_addr", port_c_address, 8'h10);
      chk("single_data", port_c_data, 8'hAA);
      chk("single_ack0", ack0, 1);
      chk("single_ack1", ack1, 0);
      @(negedge clk); req0 = 0;
      @(posedge clk); #2;
      chk("single_we_off", port_c_we, 0);
      chk("single_mem", dut_mem[8'h10], 8'hAA);

      // Held loader request: one write every other cycle
      @(negedge clk); req1 = 1; addr1 = 8'h40; data1 = 8'h33;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #2;
         if (port_c_we === 1'b1 && ack1 === 1'b1) cnt++;
         chk("held_pattern", port_c_we, (k % 2 == 0) ? 1 : 0);
      end
      @(negedge clk); req1 = 0;
      chk("held_writes", cnt, 3);

      // Randomised requesters with occasional reset
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         step_req(ack0, req0, addr0, data0);
         step_req(ack1, req1, addr1, data1);
      end
      @(negedge clk); rst = 0; req0 = 0; req1 = 0;
      repeat (4) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_wr_arbiter.md
# ram_wr_arbiter

Write-port controller for the three-port data RAM (two read ports A/B, one write port C). It shares write port C between two requesters, the CPU write-back stage (requester 0) and the external loader (requester 1), using round-robin arbitration and a req/ack handshake. Optionally, after reset it first runs a clear sequencer that writes a fill value to every RAM word. It sits directly between the requesters and the RAM write port. Read ports A/B are not touched.

## Interface
- AWIDTH, 8, RAM address width; the RAM holds 2**AWIDTH words.
- WIDTH, 8, RAM data width.
- FILL, 0, word written to every address by the clear sequencer.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  CPU write request; held until ack0 is seen.
- addr0  in  AWIDTH  CPU write address; stable while req0 is high.
- data0  in  WIDTH  CPU write data; stable while req0 is high.
- ack0  out  1  one-cycle pulse; the CPU write is on port C this cycle.
- req1, addr1, data1, ack1: same as the above, for the loader.
- busy  out  1  clear sequencer running; requests are not served.
- port_c_address  out  AWIDTH  to RAM port C address.
- port_c_data  out  WIDTH  to RAM port C data.
- port_c_we  out  1  to RAM port C write enable.

## Operation
- All outputs are registered. Reset values:
  - port_c_we = 0, port_c_address = 0, port_c_data = 0.
  - ack0 = ack1 = 0.
  - busy = 1 with RAM_CLEAR_EN defined, 0 without it.
  - Internal last-grant pointer = 1, so requester 0 wins the first tie.
- State machine CLEAR -> IDLE. CLEAR exists only with RAM_CLEAR_EN defined.
- CLEAR:
  - Counter cnt (AWIDTH bits) starts at 0.
  - Each cycle drives port_c_we = 1, port_c_address = cnt, port_c_data = FILL, then cnt increments.
  - After address 2**AWIDTH-1 has been written, the block enters IDLE. busy falls in the same cycle that we falls.
  - The counter never wraps back into a second pass.
  - req0/req1 are ignored during CLEAR and no ack is issued. Requests stay pending and are served from IDLE.
- IDLE, each rising edge:
  - A requester is eligible when its req = 1 and its ack is not high in this cycle. This blocks a held req from being granted twice.
  - No eligible requester: port_c_we = 0 and both acks = 0. Address and data hold their last values.
  - One eligible requester: it is granted.
  - Both eligible: grant the one that is not the last-grant pointer.
  - On a grant: port_c_we = 1, port_c_address/port_c_data take the winner's addr/data, the winner's ack = 1, and the pointer updates to the winner.
- Requester rules:
  - Sample ack on a rising edge.
  - May change addr/data or drop req in the cycle after ack.
  - Dropping req before ack withdraws the request with no write.
- Only one ack is high in any cycle. ack0 and ack1 are never both 1.

## Timing
- Request-to-write latency: 1 cycle. A req sampled at edge N gives we/ack high in cycle N+1, and the RAM captures the data at edge N+1.
- A single requester holding req continuously is served every second cycle.
- Two requesters holding req continuously alternate with no idle cycle: one write per cycle, 0,1,0,1...
- Clear duration: exactly 2**AWIDTH cycles with we = 1, starting the cycle after rst is released.
- rst asserted at any point, including mid-clear or mid-grant:
  - Next edge: we = 0, acks = 0.
  - Sequencer restarts from cnt = 0 after release.
  - A write in flight is abandoned. The requester re-issues it.

## Configuration
- RAM_CLEAR_EN defined: CLEAR state, counter and FILL writes are compiled in, and busy = 1 from reset until the clear completes.
- RAM_CLEAR_EN undefined: the block starts in IDLE after reset, busy is tied to 0, and FILL is unused. RAM contents after reset are undefined.

## Test plan
- Clear (RAM_CLEAR_EN, AWIDTH=8, FILL=8'h5A): release rst, then 256 consecutive cycles with we = 1 and addresses 00..FF in order, data 5A. busy falls with we. Port A reads of 00, 7F and FF return 5A.
- Single write: req0 with addr 8'h10, data 8'hAA. The next cycle has we = 1, address 10, data AA and ack0 = 1. A port A read of 10 then returns AA.
- Tie and alternation: req0 (20/11) and req1 (30/22) asserted in the same cycle and held. Writes go 20/11 with ack0, then 30/22 with ack1, then alternate. acks are never both high.
- Held single request: req1 held for 6 cycles gives we pulses every other cycle (3 writes) and ack1 aligned with each pulse.
- Request during clear: req0 asserted at clear count 8'h40 gets no ack until busy = 0. The first IDLE grant then writes the CPU value.
- Reset mid-clear: rst pulsed at count 8'h80, then the clear restarts at 00 and runs the full 256 cycles.
